// File: rtl/taxi_eth_frame_gen.sv
// Synthetic Ethernet test-frame source for a MAC transmit AXI-stream.
// Each frame is dst/src/type/seq followed by an incrementing byte pattern.

module taxi_eth_frame_gen_lane (
  input  logic [143:0] hdr,
  input  logic [15:0]  off,
  output logic [7:0]   byte_o
);
  logic [143:0] sh;
  always_comb begin
    sh     = hdr << {off[4:0], 3'b000};
    byte_o = (off < 16'd18) ? sh[143:136] : off[7:0];
  end
endmodule

module taxi_eth_frame_gen #(
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = DATA_W/8,
  parameter int MAX_LEN = 9214,
  parameter int MIN_LEN = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       cfg_frame_count,
  input  logic [15:0]       cfg_frame_len,
  input  logic [7:0]        cfg_ifg_cycles,
  input  logic [47:0]       cfg_eth_dst,
  input  logic [47:0]       cfg_eth_src,
  input  logic [15:0]       cfg_eth_type,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              busy,
  output logic [31:0]       frames_sent,
  output logic              run_done
);
  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  // Reset asserts asynchronously, releases synchronously to clk.
  logic [1:0] rst_sync_q;
  logic       rst_i_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_i_n = rst_sync_q[1];

  state_t      state_q, state_d;
  logic [15:0] k_q, k_d, len_q, len_d;
  logic [31:0] seq_q, seq_d, frames_q, frames_d;
  logic [7:0]  ifg_q, ifg_d;
  logic        run_done_q, run_done_d, stop_pend_q, stop_pend_d;

  logic [15:0] len_clamp;
  logic [31:0] frames_inc;
  logic        tvalid, last_beat, hs, run_end;

  always_comb begin
    len_clamp  = (cfg_frame_len < MIN_L) ? MIN_L :
                 (cfg_frame_len > MAX_L) ? MAX_L : cfg_frame_len;
    tvalid     = (state_q == FRAME);
    last_beat  = (17'(k_q) + 17'd8) >= 17'(len_q);
    hs         = tvalid & m_axis_tready;
    frames_inc = frames_q + 32'd1;
    run_end    = stop | stop_pend_q |
                 ((cfg_frame_count != 32'd0) && (frames_inc == cfg_frame_count));
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    len_d       = len_q;
    seq_d       = seq_q;
    frames_d    = frames_q;
    ifg_d       = ifg_q;
    run_done_d  = 1'b0;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = FRAME;
        k_d         = '0;
        len_d       = len_clamp;
        seq_d       = '0;
        frames_d    = '0;
        stop_pend_d = stop;
      end
      FRAME: begin
        // A stop pulse seen mid-frame is remembered so the run still ends
        // cleanly at this frame's last beat.
        if (stop) stop_pend_d = 1'b1;
        if (hs) begin
          if (last_beat) begin
            frames_d = frames_inc;
            seq_d    = seq_q + 32'd1;
            k_d      = '0;
            if (run_end) begin
              state_d     = IDLE;
              run_done_d  = 1'b1;
              stop_pend_d = 1'b0;
            end else if (cfg_ifg_cycles == 8'd0) begin
              len_d = len_clamp;
            end else begin
              state_d = GAP;
              ifg_d   = cfg_ifg_cycles;
            end
          end else begin
            k_d = k_q + 16'd8;
          end
        end
      end
      GAP: begin
        if (stop | stop_pend_q) begin
          state_d     = IDLE;
          run_done_d  = 1'b1;
          stop_pend_d = 1'b0;
        end else if (ifg_q <= 8'd1) begin
          state_d = FRAME;
          len_d   = len_clamp;
        end else begin
          ifg_d = ifg_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      len_q       <= MIN_L;
      seq_q       <= '0;
      frames_q    <= '0;
      ifg_q       <= '0;
      run_done_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      len_q       <= len_d;
      seq_q       <= seq_d;
      frames_q    <= frames_d;
      ifg_q       <= ifg_d;
      run_done_q  <= run_done_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  logic [143:0]            hdr;
  logic [KEEP_W-1:0][7:0]  lane_byte;
  logic [KEEP_W-1:0]       keep_last;
  assign hdr = {cfg_eth_dst, cfg_eth_src, cfg_eth_type, seq_q};

  for (genvar i = 0; i < KEEP_W; i++) begin : g_lane
    taxi_eth_frame_gen_lane u_lane (
      .hdr    (hdr),
      .off    (k_q + 16'(i)),
      .byte_o (lane_byte[i])
    );
  end

  always_comb begin
    keep_last = (len_q[2:0] == 3'd0) ? '1 :
                ((KEEP_W'(1) << len_q[2:0]) - KEEP_W'(1));
    m_axis_tvalid = tvalid;
    m_axis_tdata  = tvalid ? DATA_W'(lane_byte) : '0;
    m_axis_tkeep  = !tvalid ? '0 : (last_beat ? keep_last : '1);
    m_axis_tlast  = tvalid & last_beat;
    m_axis_tuser  = 1'b0;
    busy          = (state_q != IDLE);
    frames_sent   = frames_q;
    run_done      = run_done_q;
  end
endmodule

// File: tb/tb_taxi_eth_frame_gen.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor checks them.
module tb_taxi_eth_frame_gen;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] cfg_frame_count = '0;
  logic [15:0] cfg_frame_len = 16'd64;
  logic [7:0]  cfg_ifg_cycles = '0;
  logic [47:0] cfg_eth_dst = 48'h0A1B2C3D4E5F;
  logic [47:0] cfg_eth_src = 48'h112233445566;
  logic [15:0] cfg_eth_type = 16'h88B5;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready = 1'b1, tlast, tuser, busy, run_done;
  logic [31:0] frames_sent;

  taxi_eth_frame_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_frame_count(cfg_frame_count), .cfg_frame_len(cfg_frame_len),
    .cfg_ifg_cycles(cfg_ifg_cycles), .cfg_eth_dst(cfg_eth_dst),
    .cfg_eth_src(cfg_eth_src), .cfg_eth_type(cfg_eth_type),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .busy(busy), .frames_sent(frames_sent), .run_done(run_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
  beat_t q[$];

  int total = 0, bad = 0;
  int cyc = 0, last_cyc = 0, exp_gap = 0, rd_cnt = 0, beat_idx = 0, frame_idx = 0;
  bit bp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input logic [31:0] s);
    logic [31:0] kk;
    kk = k;
    if (k < 6)       return cfg_eth_dst[8*(5-k) +: 8];
    else if (k < 12) return cfg_eth_src[8*(11-k) +: 8];
    else if (k < 14) return cfg_eth_type[8*(13-k) +: 8];
    else if (k < 18) return s[8*(17-k) +: 8];
    return kk[7:0];
  endfunction

  task automatic push_frame(input int len_raw, input logic [31:0] s);
    int L, nb;
    beat_t b;
    L  = (len_raw < 18) ? 18 : (len_raw > 9214) ? 9214 : len_raw;
    nb = (L + 7) / 8;
    for (int bi = 0; bi < nb; bi++) begin
      for (int i = 0; i < 8; i++) b.data[8*i +: 8] = exp_byte(8*bi + i, s);
      b.last = (bi == nb - 1);
      b.keep = (b.last && (L % 8) != 0) ? 8'((1 << (L % 8)) - 1) : 8'hFF;
      q.push_back(b);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1 tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    bit stalled, have_prev, sop;
    logic [63:0] held_d;
    logic [9:0]  held_c;
    beat_t e;
    logic [63:0] m;
    stalled = 0; have_prev = 0; sop = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0; have_prev = 0; sop = 1; beat_idx = 0; frame_idx = 0;
        continue;
      end
      if (stalled) begin
        chk("hold_data", tdata, held_d);
        chk("hold_ctl", {tvalid, tlast, tkeep}, held_c);
      end
      stalled = tvalid & !tready;
      held_d = tdata; held_c = {tvalid, tlast, tkeep};
      if (tvalid && sop) begin
        sop = 0;
        if (have_prev) chk("ifg_gap", cyc - last_cyc - 1, exp_gap);
      end
      if (tvalid && tready) begin
        chk("tuser", tuser, 0);
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{e.keep[i]}};
          chk("tdata", tdata & m, e.data & m);
          chk("tkeep", tkeep, e.keep);
          chk("tlast", tlast, e.last);
        end
        beat_idx++;
        if (tlast) begin
          last_cyc = cyc; have_prev = 1; sop = 1; beat_idx = 0; frame_idx++;
        end
      end
      if (run_done) begin
        rd_cnt++;
        chk("run_done_lat", cyc, last_cyc + 1);
        chk("busy_fall", busy, 0);
        have_prev = 0; frame_idx = 0;
      end
    end
  end

  task automatic pulse_start(input logic with_stop);
    @(posedge clk); #1 start = 1; stop = with_stop;
    @(posedge clk); #1 start = 0; stop = 0;
  endtask

  task automatic wait_run(input int r0, input int bound);
    int n;
    n = 0;
    while (rd_cnt == r0 && n < bound) begin @(posedge clk); #1; n++; end
    if (rd_cnt == r0) chk("run_timeout", 0, 1);
  endtask

  task automatic run(input int len, input int cnt, input int ifg, input int bound);
    int r0;
    cfg_frame_len = 16'(len); cfg_frame_count = cnt; cfg_ifg_cycles = 8'(ifg);
    exp_gap = ifg;
    for (int f = 0; f < cnt; f++) push_frame(len, f);
    r0 = rd_cnt;
    pulse_start(1'b0);
    wait_run(r0, bound);
    @(posedge clk); #1;
    chk("frames_sent", frames_sent, cnt);
    chk("busy_idle", busy, 0);
    chk("q_empty", q.size(), 0);
  endtask

  initial begin
    int r0, n;
    repeat (3) @(posedge clk);
    #1 chk("rst_tvalid", tvalid, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_tvalid2", tvalid, 0); chk("rst_tkeep", tkeep, 0);
    chk("rst_tdata", tdata, 0);    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0); chk("rst_run_done", run_done, 0);

    run(64, 1, 0, 100);      // single frame, seq 0, byte 18 = 0x12
    run(61, 3, 4, 200);      // partial last beat, 4-cycle gaps
    run(5, 1, 0, 100);       // clamp low -> 18 bytes
    run(20000, 1, 0, 2000);  // clamp high -> 9214 bytes
    bp_en = 1;
    run(100, 10, 2, 2000);   // random backpressure
    bp_en = 0;

    // Continuous run, stop during beat 3 of frame 5; a start mid-run is ignored
    cfg_frame_len = 16'd64; cfg_frame_count = 0; cfg_ifg_cycles = 8'd1; exp_gap = 1;
    for (int f = 0; f < 5; f++) push_frame(64, f);
    r0 = rd_cnt;
    pulse_start(1'b0);
    repeat (15) @(posedge clk);
    pulse_start(1'b0);
    n = 0;
    while (!(frame_idx == 4 && beat_idx == 3) && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) chk("stop_trigger_timeout", 0, 1);
    stop = 1;
    wait_run(r0, 200);
    stop = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("stop_frames", frames_sent, 5);
    chk("stop_run_done_once", rd_cnt - r0, 1);
    chk("stop_q_empty", q.size(), 0);

    // start and stop together: exactly one frame
    cfg_frame_len = 16'd18; cfg_frame_count = 0; cfg_ifg_cycles = 8'd0;
    push_frame(18, 0);
    r0 = rd_cnt;
    pulse_start(1'b1);
    wait_run(r0, 100);
    repeat (5) @(posedge clk);
    #1;
    chk("ss_frames", frames_sent, 1);
    chk("ss_q_empty", q.size(), 0);

    // Reset mid-frame
    cfg_frame_len = 16'd200; cfg_frame_count = 1;
    push_frame(200, 0);
    pulse_start(1'b0);
    n = 0;
    while (beat_idx < 3 && n < 100) begin @(posedge clk); #1; n++; end
    #2 rst_n = 1'b0;
    #1 chk("async_rst_tvalid", tvalid, 0);
    chk("async_rst_busy", busy, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_frames", frames_sent, 0);
    chk("post_rst_tvalid", tvalid, 0);
    run(64, 1, 0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/taxi_eth_frame_gen.md
Name: taxi_eth_frame_gen

Overview:
- Synthetic Ethernet frame source. Drives a MAC transmit AXI-stream (s_axis_tx side of the MAC) with sequence-numbered test frames.
- Serves as the transmit end of a link test. Frames cross the link, are looped back by the far-end FIFO loopback, and are returned for checking.
- The MAC appends the FCS and padding; this block emits header plus payload only.

Parameters:
DATA_W, 64, stream data width in bits; 64 only supported (8 bytes/beat)
KEEP_W, DATA_W/8, tkeep width
MAX_LEN, 9214, upper clamp on frame length in bytes (excluding FCS)
MIN_LEN, 18, lower clamp on frame length (header + sequence number)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a run (ignored unless idle)
stop  in  1  level; end run after the frame in progress
cfg_frame_count  in  32  frames per run; 0 = continuous
cfg_frame_len  in  16  frame length in bytes, sampled at each frame start
cfg_ifg_cycles  in  8  idle cycles inserted between frames
cfg_eth_dst  in  48  destination MAC
cfg_eth_src  in  48  source MAC
cfg_eth_type  in  16  EtherType
m_axis_tdata  out  DATA_W  stream data
m_axis_tkeep  out  KEEP_W  byte enables
m_axis_tvalid  out  1  valid
m_axis_tready  in  1  ready
m_axis_tlast  out  1  last beat
m_axis_tuser  out  1  bad-frame flag; always 0
busy  out  1  run in progress
frames_sent  out  32  frames completed in the current run
run_done  out  1  one-cycle pulse when a run ends

Behaviour:
- Reset (rst_n low, async): state IDLE. tvalid=0, tlast=0, tkeep=0, tdata=0, tuser=0, busy=0, frames_sent=0, run_done=0, seq=0. Deassertion is synchronised internally.
- States: IDLE, FRAME, GAP.
- IDLE -> FRAME on start. Actions: busy=1, frames_sent=0, seq=0, latch clamp(cfg_frame_len, MIN_LEN, MAX_LEN).
- FRAME: byte offset k increments by 8 per accepted beat (tvalid & tready).
- Frame byte layout, byte 0 = tdata[7:0] of beat 0:
  - k 0-5: cfg_eth_dst, MSB first.
  - k 6-11: cfg_eth_src, MSB first.
  - k 12-13: cfg_eth_type, big-endian.
  - k 14-17: seq[31:0], big-endian.
  - k >= 18: byte value k[7:0].
- Beat count = ceil(len/8). On the last beat, tlast=1 and tkeep = low (len mod 8, 0 => 8) bits set. All other beats have tkeep all ones.
- AXI-stream rules:
  - Once tvalid is asserted, tdata/tkeep/tlast stay stable and tvalid stays high until tready.
  - No bubbles within a frame: tvalid remains 1 while tready is low.
  - Throughput is 1 beat/cycle when tready=1.
- On the last beat's handshake:
  - frames_sent += 1 and seq += 1, both wrapping at 2^32.
  - If stop=1, or cfg_frame_count != 0 and the new frames_sent == cfg_frame_count: go to IDLE, busy=0, run_done=1 for one cycle.
  - Otherwise, if cfg_ifg_cycles == 0: go directly to FRAME. The next frame's first beat is valid the following cycle, and length is re-sampled.
  - Otherwise go to GAP.
- GAP: tvalid=0 for exactly cfg_ifg_cycles cycles (counter loaded at entry), then FRAME. stop seen in GAP -> IDLE immediately with run_done pulse.
- stop asserted mid-frame never truncates a frame.
- start while busy is ignored.
- start and stop high in the same IDLE cycle: start wins; the run ends after the first frame.
- Config changes mid-frame: length is latched per frame; MAC/EtherType fields are sampled live and must be held stable by the user during a run.
- frames_sent holds its value after the run ends until the next start.

Test Plan:
- start, cfg_frame_count=1, len=64, tready=1 -> 8 beats; beat 7 has tlast=1, tkeep=0xFF; bytes 14-17 = 00 00 00 00; byte 18 = 0x12; run_done pulses 1 cycle after the last beat; frames_sent=1.
- len=61, count=3, ifg=4 -> 8 beats/frame; last tkeep=0x1F; exactly 4 idle cycles between frames; seq 0,1,2; busy falls with run_done.
- len=5 and len=20000 -> clamped to 18 (3 beats, last tkeep=0x03) and 9214 (1152 beats, last tkeep=0x3F).
- Random tready backpressure 50%, count=10, len=100 -> no data/tkeep change while stalled; frame contents match the reference model; frames_sent=10.
- count=0 continuous; assert stop during beat 3 of frame 5 -> frame 5 completes fully; no frame 6; run_done pulses once; frames_sent=5.
- rst_n pulled low mid-frame -> tvalid=0 asynchronously; after release, state IDLE with seq=0; next start emits seq 0.
